// File: rtl/fxp_div_seq_if.sv
// rtl/fxp_div_seq_if.sv - request/result bundle for the sequential Q1.(size-1) divider
//   start, dividend, divisor : request side, driven by the master
//   quotient, busy, done     : result and status, driven by the divider (slave)
//   div_by_zero, overflow    : result flags, held alongside quotient
interface fxp_div_seq_if #(
   parameter int size = 16
);
   logic            start;
   logic [size-1:0] dividend;
   logic [size-1:0] divisor;
   logic [size-1:0] quotient;
   logic            busy;
   logic            done;
   logic            div_by_zero;
   logic            overflow;

   modport master (
      output start, dividend, divisor,
      input  quotient, busy, done, div_by_zero, overflow
   );

   modport slave (
      input  start, dividend, divisor,
      output quotient, busy, done, div_by_zero, overflow
   );
endinterface

// File: rtl/fxp_div_seq.sv
// rtl/fxp_div_seq.sv - signed Q1.(size-1) restoring divider, one quotient bit per clock
//   clk, rst : clock and asynchronous active-high reset
//   bus      : start/dividend/divisor in; quotient/busy/done/div_by_zero/overflow out
module fxp_div_seq #(
   parameter int size = 16
) (
   input logic          clk,
   input logic          rst,
   fxp_div_seq_if.slave bus
);
   localparam int cnt_w = $clog2(size);
   localparam logic [size-1:0] one_v   = {{(size-1){1'b0}}, 1'b1};
   localparam logic [size-1:0] max_pos = {1'b0, {(size-1){1'b1}}};
   localparam logic [size-1:0] min_neg = {1'b1, {(size-1){1'b0}}};
   localparam logic [cnt_w-1:0] cnt_load = cnt_w'(size - 1);
   localparam logic [cnt_w-1:0] cnt_last = cnt_w'(1);

   typedef enum logic [1:0] {st_idle, st_calc, st_done} state_t;

   state_t          state, state_nx;
   logic [size:0]   rem;        // one spare bit so 2R never overflows
   logic [size-1:0] mag_b;
   logic [size-2:0] qsh;        // magnitude bits 2^-1 .. 2^-(size-1)
   logic [cnt_w-1:0] cnt;
   logic            sign;
   logic [size-1:0] q_reg;
   logic            dz_reg;
   logic            ov_reg;

   // Request-side decode, only meaningful while idle
   logic [size-1:0] abs_a, abs_b;
   logic            sign_in, is_zero, is_neg_one, is_sat, special;

   always_comb begin
      // Two's-complement magnitude; -1.0 maps to 2^(size-1), which fits unsigned
      abs_a      = bus.dividend[size-1] ? (~bus.dividend + one_v) : bus.dividend;
      abs_b      = bus.divisor[size-1]  ? (~bus.divisor  + one_v) : bus.divisor;
      sign_in    = bus.dividend[size-1] ^ bus.divisor[size-1];
      is_zero    = (bus.divisor == '0);
      is_neg_one = (abs_a == abs_b) && sign_in;
      is_sat     = (abs_a >= abs_b);
      special    = is_zero || is_sat;
   end

   // One restoring step
   logic [size:0]   r2, rem_nx;
   logic            ge;
   logic [size-2:0] q_nx;

   always_comb begin
      r2     = rem << 1;
      ge     = (r2 >= {1'b0, mag_b});
      rem_nx = ge ? (r2 - {1'b0, mag_b}) : r2;
      q_nx   = {qsh[size-3:0], ge};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= st_idle;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         st_idle: if (bus.start) state_nx = special ? st_done : st_calc;
         st_calc: if (cnt == cnt_last) state_nx = st_done;
         st_done: state_nx = st_idle;
         default: state_nx = st_idle;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rem    <= '0;
         mag_b  <= '0;
         qsh    <= '0;
         cnt    <= '0;
         sign   <= 1'b0;
         q_reg  <= '0;
         dz_reg <= 1'b0;
         ov_reg <= 1'b0;
      end else begin
         case (state)
            st_idle: begin
               if (bus.start) begin
                  rem   <= {1'b0, abs_a};
                  mag_b <= abs_b;
                  qsh   <= '0;
                  cnt   <= cnt_load;
                  sign  <= sign_in;
                  // Priority: zero divisor, then exact -1.0, then saturation
                  if (is_zero) begin
                     q_reg  <= bus.dividend[size-1] ? min_neg : max_pos;
                     dz_reg <= 1'b1;
                     ov_reg <= 1'b0;
                  end else if (is_neg_one) begin
                     q_reg  <= min_neg;
                     dz_reg <= 1'b0;
                     ov_reg <= 1'b0;
                  end else if (is_sat) begin
                     q_reg  <= sign_in ? min_neg : max_pos;
                     dz_reg <= 1'b0;
                     ov_reg <= 1'b1;
                  end
               end
            end
            st_calc: begin
               rem <= rem_nx;
               qsh <= q_nx;
               cnt <= cnt - cnt_last;
               if (cnt == cnt_last) begin
                  q_reg  <= sign ? (~{1'b0, q_nx} + one_v) : {1'b0, q_nx};
                  dz_reg <= 1'b0;
                  ov_reg <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.quotient    = q_reg;
   assign bus.div_by_zero = dz_reg;
   assign bus.overflow    = ov_reg;
   assign bus.busy        = (state != st_idle);
   assign bus.done        = (state == st_done);
endmodule

// File: tb/tb_fxp_div_seq.sv
// tb/tb_fxp_div_seq.sv - bench for fxp_div_seq against an arithmetic reference model
module tb_fxp_div_seq;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   always #5 clk = ~clk;

   fxp_div_seq_if #(.size(16)) bus ();
   fxp_div_seq #(.size(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // {div_by_zero, overflow, quotient} from plain integer arithmetic
   function automatic logic [17:0] ref_div(input logic [15:0] a, input logic [15:0] b);
      longint sa, sb, t;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sb == 0) return {2'b10, (sa >= 0) ? 16'h7fff : 16'h8000};
      t = (sa * 32768) / sb;
      if (t > 32767)  return {2'b01, 16'h7fff};
      if (t < -32768) return {2'b01, 16'h8000};
      return {2'b00, t[15:0]};
   endfunction

   function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
      longint sa, sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sa < 0) sa = -sa;
      if (sb < 0) sb = -sb;
      return (sa < sb) ? 16 : 1;
   endfunction

   task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                         output logic [17:0] res, output int lat, output int bcnt);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = a;
      bus.divisor  = b;
      @(posedge clk);
      #1 bus.start = 1'b0;
      lat  = 0;
      bcnt = 0;
      do begin
         @(negedge clk);
         lat++;
         if (bus.busy) bcnt++;
      end while (!bus.done && lat < 40);
      check("done_seen", bus.done, 1'b1);
      res = {bus.div_by_zero, bus.overflow, bus.quotient};
      @(negedge clk);
      check("done_single", bus.done, 1'b0);
      check("busy_drop", bus.busy, 1'b0);
   endtask

   typedef struct {
      logic [15:0] a, b, q;
      logic        dz, ov;
      int          lat;
   } vec_t;

   vec_t vecs[$];
   logic [17:0] res;
   int lat, bcnt, ndone;
   logic [15:0] ra, rb;

   initial begin
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      vecs.push_back('{16'h2000, 16'h4000, 16'h4000, 1'b0, 1'b0, 16});
      vecs.push_back('{16'h1000, 16'h3000, 16'h2aaa, 1'b0, 1'b0, 16});
      vecs.push_back('{16'hf000, 16'h3000, 16'hd556, 1'b0, 1'b0, 16});
      vecs.push_back('{16'h1234, 16'h0000, 16'h7fff, 1'b1, 1'b0, 1});
      vecs.push_back('{16'h8000, 16'h0000, 16'h8000, 1'b1, 1'b0, 1});
      vecs.push_back('{16'h4000, 16'h2000, 16'h7fff, 1'b0, 1'b1, 1});
      vecs.push_back('{16'h8000, 16'h8000, 16'h7fff, 1'b0, 1'b1, 1});
      vecs.push_back('{16'hc000, 16'h4000, 16'h8000, 1'b0, 1'b0, 1});
      vecs.push_back('{16'h8000, 16'h7fff, 16'h8000, 1'b0, 1'b1, 1});

      repeat (3) @(posedge clk);
      #1;
      check("rst_q", bus.quotient, 16'h0);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_done", bus.done, 1'b0);
      check("rst_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
      @(negedge clk);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_op(vecs[i].a, vecs[i].b, res, lat, bcnt);
         check($sformatf("q_%0d", i), res[15:0], vecs[i].q);
         check($sformatf("dz_%0d", i), res[17], vecs[i].dz);
         check($sformatf("ov_%0d", i), res[16], vecs[i].ov);
         check($sformatf("lat_%0d", i), lat, vecs[i].lat);
         check($sformatf("busy_%0d", i), bcnt, vecs[i].lat);
      end

      // start pulsed mid-calculation must be ignored
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'h1000; bus.divisor = 16'h3000;
      @(negedge clk);
      bus.start = 1'b0;
      ndone = 0;
      for (int c = 0; c < 20; c++) begin
         if (c == 3) begin
            bus.start = 1'b1; bus.dividend = 16'h2000; bus.divisor = 16'h4000;
         end else begin
            bus.start = 1'b0;
         end
         if (bus.done) begin
            ndone++;
            check("ign_q", bus.quotient, 16'h2aaa);
         end
         @(negedge clk);
      end
      check("ign_ndone", ndone, 1);
      run_op(16'h2000, 16'h4000, res, lat, bcnt);
      check("after_ign_q", res, {2'b00, 16'h4000});
      check("after_ign_lat", lat, 16);

      // reset in the middle of a calculation
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'h1000; bus.divisor = 16'h3000;
      @(posedge clk);
      #1 bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mrst_q", bus.quotient, 16'h0);
      check("mrst_busy", bus.busy, 1'b0);
      check("mrst_done", bus.done, 1'b0);
      check("mrst_flags", {bus.div_by_zero, bus.overflow}, 2'b00);
      ndone = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done) ndone++;
      end
      check("mrst_nodone", ndone, 0);
      rst = 1'b0;
      run_op(16'h1000, 16'h3000, res, lat, bcnt);
      check("post_rst_q", res, {2'b00, 16'h2aaa});
      check("post_rst_lat", lat, 16);

      // start held high: one result per 17 cycles
      @(negedge clk);
      bus.start = 1'b1; bus.dividend = 16'h2000; bus.divisor = 16'h4000;
      ndone = 0;
      repeat (51) begin
         @(negedge clk);
         if (bus.done) begin
            ndone++;
            check("held_q", bus.quotient, 16'h4000);
         end
      end
      check("held_ndone", ndone, 3);
      bus.start = 1'b0;
      lat = 0;
      while (bus.busy && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("held_idle", bus.busy, 1'b0);

      // random sweep
      for (int n = 0; n < 2000; n++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 9))
            0:       rb = 16'h0000;
            1:       rb = 16'($urandom_range(0, 15)) ^ {16{ra[15]}};
            2:       rb = ra;
            default: rb = 16'($urandom);
         endcase
         run_op(ra, rb, res, lat, bcnt);
         check($sformatf("rnd_%h_%h", ra, rb), res, ref_div(ra, rb));
         check($sformatf("rnd_lat_%h_%h", ra, rb), lat, ref_lat(ra, rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
